// File: rtl/rom_addr_seq_pkg.sv
// ---------------------------------------------------------------------------
// rom_addr_seq_pkg
//   Constants and types shared by the LED-pattern ROM address sequencer and
//   the downstream ROM-to-LED stage.
//     ROM_ADDR_W          : ROM address width
//     STEP_DIV_DEFAULT    : clk_1m cycles per address step (10 Hz at 1 MHz)
//     STEP_DIV_W_DEFAULT  : width of the step divider counter
//     seq_state_t         : sequencer state (IDLE / RUN / PAUSE)
// ---------------------------------------------------------------------------
package rom_addr_seq_pkg;

  localparam int ROM_ADDR_W         = 14;
  localparam int STEP_DIV_DEFAULT   = 100000;
  localparam int STEP_DIV_W_DEFAULT = 17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } seq_state_t;

endpackage : rom_addr_seq_pkg

// File: rtl/rom_addr_seq_step_tick_div.sv
// ---------------------------------------------------------------------------
// step_tick_div
//   Step-rate divider. Counts enabled cycles 0..DIV-1 and flags the cycle in
//   which the count sits at DIV-1 (the counter returns to 0 on that edge).
//   Ports:
//     clk_1m    : clock
//     sys_rst_n : asynchronous active-low reset
//     en        : count this cycle (sequencer active and not paused)
//     clr       : synchronous clear, wins over en
//     tick      : one-cycle strobe, high while count == DIV-1 and en
// ---------------------------------------------------------------------------
module step_tick_div #(
  parameter int DIV   = 100000,
  parameter int DIV_W = 17
) (
  input  logic clk_1m,
  input  logic sys_rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // tick is decoded from the count so the consumer can act on the same edge
  // that wraps the counter back to 0.
  assign tick = en && !clr && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_1m or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : step_tick_div

// File: rtl/rom_addr_seq.sv
// ---------------------------------------------------------------------------
// rom_addr_seq
//   Walks the LED-pattern ROM address through a [lo, hi] window, one address
//   per DIV clk_1m cycles, with start/restart, pause, live direction and
//   one-shot/loop control.
//   Ports:
//     clk_1m            : 1 MHz clock
//     sys_rst_n         : asynchronous active-low reset
//     start             : one-cycle pulse, latches bounds and (re)starts
//     pause             : level, freezes stepping while high
//     dir               : 0 ascending, 1 descending (sampled at each step)
//     loop_en           : 1 wrap at the window end, 0 stop (one-shot)
//     lo_addr, hi_addr  : window bounds, sampled only on start (any order)
//     addr              : current ROM address (registered)
//     step              : one-cycle pulse whenever addr is loaded or changes
//     busy              : high while RUN or PAUSE
//     done              : one-cycle pulse when a one-shot sequence ends
// ---------------------------------------------------------------------------
module rom_addr_seq
  import rom_addr_seq_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DIV    = STEP_DIV_DEFAULT,
  parameter int DIV_W  = STEP_DIV_W_DEFAULT
) (
  input  logic              clk_1m,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic              pause,
  input  logic              dir,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] lo_addr,
  input  logic [ADDR_W-1:0] hi_addr,
  output logic [ADDR_W-1:0] addr,
  output logic              step,
  output logic              busy,
  output logic              done
);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] lo_q, lo_d;
  logic [ADDR_W-1:0] hi_q, hi_d;
  logic              step_q, step_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              active;
  logic              tick;
  logic              at_end;
  logic [ADDR_W-1:0] start_lo;
  logic [ADDR_W-1:0] start_hi;

  // The divider also runs in the cycle PAUSE is left, so each paused cycle
  // costs exactly one cycle of delay.
  assign active = (state_q != IDLE) && !pause;

  step_tick_div #(
    .DIV   (DIV),
    .DIV_W (DIV_W)
  ) u_div (
    .clk_1m    (clk_1m),
    .sys_rst_n (sys_rst_n),
    .en        (active),
    .clr       (start),
    .tick      (tick)
  );

  assign start_lo = (lo_addr <= hi_addr) ? lo_addr : hi_addr;
  assign start_hi = (lo_addr <= hi_addr) ? hi_addr : lo_addr;

  // addr always lies in [lo_q, hi_q], so stepping away from the end bound
  // can never leave the window or wrap modulo 2^ADDR_W.
  assign at_end = dir ? (addr_q == lo_q) : (addr_q == hi_q);

  // State register (all flops)
  always_ff @(posedge clk_1m or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = RUN;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        RUN, PAUSE: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (tick && at_end && !loop_en) begin
            state_d = IDLE;
          end else begin
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output / datapath logic
  always_comb begin
    addr_d = addr_q;
    lo_d   = lo_q;
    hi_d   = hi_q;
    step_d = 1'b0;
    done_d = 1'b0;
    if (start) begin
      lo_d   = start_lo;
      hi_d   = start_hi;
      addr_d = dir ? start_hi : start_lo;
      step_d = 1'b1;
    end else if (tick) begin
      if (!at_end) begin
        addr_d = dir ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));
        step_d = 1'b1;
      end else if (loop_en) begin
        addr_d = dir ? hi_q : lo_q;
        step_d = 1'b1;
      end else begin
        done_d = 1'b1;
      end
    end
    busy_d = (state_d != IDLE);
  end

  assign addr = addr_q;
  assign step = step_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule : rom_addr_seq

// File: tb/tb_rom_addr_seq.sv
// ---------------------------------------------------------------------------
// tb_rom_addr_seq
//   Directed scenarios followed by a randomized phase; every cycle the DUT
//   outputs are compared with a behavioural model of the sequencer rules.
// ---------------------------------------------------------------------------
module tb_rom_addr_seq;

  localparam int AW  = 14;
  localparam int DIV = 4;
  localparam logic [AW-1:0] TOP = '1;

  logic          clk_1m = 1'b0;
  logic          sys_rst_n;
  logic          start, pause, dir, loop_en;
  logic [AW-1:0] lo_addr, hi_addr;
  logic [AW-1:0] addr;
  logic          step, busy, done;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  logic [AW-1:0] m_addr, m_lo, m_hi;
  logic          m_step, m_done, m_busy;
  int            m_elapsed;

  rom_addr_seq #(
    .ADDR_W (AW),
    .DIV    (DIV),
    .DIV_W  (3)
  ) dut (
    .clk_1m    (clk_1m),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .pause     (pause),
    .dir       (dir),
    .loop_en   (loop_en),
    .lo_addr   (lo_addr),
    .hi_addr   (hi_addr),
    .addr      (addr),
    .step      (step),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk_1m = ~clk_1m;

  task automatic model_reset();
    m_addr = '0; m_lo = '0; m_hi = '0;
    m_step = 1'b0; m_done = 1'b0; m_busy = 1'b0;
    m_elapsed = 0;
  endtask

  // One clock edge of the sequencer rules: count unpaused cycles since the
  // last step; after DIV of them, move one address toward the end bound,
  // wrap, or finish.
  task automatic model_edge();
    m_step = 1'b0;
    m_done = 1'b0;
    if (!sys_rst_n) begin
      model_reset();
    end else if (start) begin
      m_lo = lo_addr;
      m_hi = hi_addr;
      if (m_lo > m_hi) begin
        m_lo = hi_addr;
        m_hi = lo_addr;
      end
      m_addr    = dir ? m_hi : m_lo;
      m_elapsed = 0;
      m_step    = 1'b1;
      m_busy    = 1'b1;
    end else if (m_busy && !pause) begin
      m_elapsed++;
      if (m_elapsed == DIV) begin
        m_elapsed = 0;
        if (!dir && m_addr < m_hi) begin
          m_addr = m_addr + 14'd1;
          m_step = 1'b1;
        end else if (dir && m_addr > m_lo) begin
          m_addr = m_addr - 14'd1;
          m_step = 1'b1;
        end else if (loop_en) begin
          m_addr = dir ? m_hi : m_lo;
          m_step = 1'b1;
        end else begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    total++;
    assert (addr === m_addr) else begin
      bad++;
      $error("FAIL %s addr got=%0d exp=%0d", tag, addr, m_addr);
    end
    total++;
    assert (step === m_step) else begin
      bad++;
      $error("FAIL %s step got=%0b exp=%0b", tag, step, m_step);
    end
    total++;
    assert (busy === m_busy) else begin
      bad++;
      $error("FAIL %s busy got=%0b exp=%0b", tag, busy, m_busy);
    end
    total++;
    assert (done === m_done) else begin
      bad++;
      $error("FAIL %s done got=%0b exp=%0b", tag, done, m_done);
    end
  endtask

  task automatic run_cycle(input string tag);
    @(posedge clk_1m);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic do_start(input logic [AW-1:0] a, input logic [AW-1:0] b,
                          input logic d, input logic l, input string tag);
    lo_addr = a; hi_addr = b; dir = d; loop_en = l; start = 1'b1;
    run_cycle(tag);
    start = 1'b0;
  endtask

  task automatic run_n(input int n, input string tag);
    for (int i = 0; i < n; i++) run_cycle(tag);
  endtask

  // Run until the model shows a step to the given address; a missed bound
  // is itself a failed comparison.
  task automatic run_until_step_at(input logic [AW-1:0] a, input int limit,
                                   input string tag);
    int n;
    n = 0;
    while (!(m_step && m_addr == a) && n < limit) begin
      run_cycle(tag);
      n++;
    end
    total++;
    assert (m_step && m_addr == a) else begin
      bad++;
      $error("FAIL %s_timeout waited=%0d exp_addr=%0d", tag, n, a);
    end
  endtask

  initial begin
    int gap;
    logic [AW-1:0] ra, rb;
    sys_rst_n = 1'b0;
    start = 1'b0; pause = 1'b0; dir = 1'b0; loop_en = 1'b0;
    lo_addr = '0; hi_addr = '0;
    model_reset();

    // reset state
    run_n(2, "reset");
    #2 sys_rst_n = 1'b1;
    run_n(3, "idle");

    // one-shot ascending 0..3, then done, addr holds
    do_start(14'd0, 14'd3, 1'b0, 1'b0, "os_asc_start");
    run_n(22, "os_asc");

    // looping descending 12,11,10,12,...
    do_start(14'd10, 14'd12, 1'b1, 1'b1, "loop_desc_start");
    run_n(30, "loop_desc");

    // pause 7 cycles starting 2 cycles after a step: gap must be 4+7
    run_until_step_at(14'd11, 20, "pause_sync");
    gap = 0;
    run_cycle("pause_pre"); gap++;
    pause = 1'b1;
    for (int i = 0; i < 7; i++) begin run_cycle("pause_hold"); gap++; end
    pause = 1'b0;
    while (!step && gap < 30) begin run_cycle("pause_resume"); gap++; end
    total++;
    assert (gap === 11) else begin
      bad++;
      $error("FAIL pause_gap got=%0d exp=11", gap);
    end

    // swapped bounds, direction flipped after reaching 3
    do_start(14'd5, 14'd2, 1'b0, 1'b1, "swap_start");
    run_until_step_at(14'd3, 20, "swap_to3");
    dir = 1'b1;
    run_n(14, "swap_rev");
    loop_en = 1'b0;
    run_n(14, "swap_oneshot");

    // window at the bottom of the address space, descending one-shot
    do_start(14'd2, 14'd0, 1'b1, 1'b0, "bot_start");
    run_n(16, "bot_desc");
    // window at the top of the address space, ascending loop
    do_start(TOP, TOP - 14'd1, 1'b0, 1'b1, "top_start");
    run_n(20, "top_asc");
    // single-address windows
    do_start(14'd9, 14'd9, 1'b0, 1'b1, "single_loop_start");
    run_n(13, "single_loop");
    do_start(14'd9, 14'd9, 1'b1, 1'b0, "single_os_start");
    run_n(8, "single_os");

    // start coinciding with the terminal one-shot step
    do_start(14'd0, 14'd1, 1'b0, 1'b0, "term_start");
    run_until_step_at(14'd1, 20, "term_to1");
    run_n(3, "term_wait");
    lo_addr = 14'd4; hi_addr = 14'd6; start = 1'b1;
    run_cycle("term_restart");
    start = 1'b0;
    total++;
    assert (addr === 14'd4 && step === 1'b1 && busy === 1'b1 && done === 1'b0)
    else begin
      bad++;
      $error("FAIL term_restart addr/step/busy/done got=%0d/%0b/%0b/%0b exp=4/1/1/0",
             addr, step, busy, done);
    end
    run_n(16, "term_after");

    // bounds changing outside start have no effect
    lo_addr = 14'd100; hi_addr = 14'd200;
    do_start(14'd20, 14'd22, 1'b0, 1'b1, "bnd_start");
    lo_addr = 14'd0; hi_addr = 14'd1;
    run_n(16, "bnd_run");

    // randomized phase
    for (int r = 0; r < 600; r++) begin
      if ($urandom_range(0, 29) == 0) begin
        case ($urandom_range(0, 3))
          0: begin ra = 14'($urandom_range(0, 3)); rb = 14'($urandom_range(0, 3)); end
          1: begin ra = TOP - 14'($urandom_range(0, 3)); rb = TOP - 14'($urandom_range(0, 3)); end
          2: begin ra = 14'($urandom_range(0, 16000)); rb = ra + 14'($urandom_range(0, 5)); end
          default: begin ra = 14'($urandom_range(0, 16383)); rb = ra; end
        endcase
        lo_addr = ra; hi_addr = rb;
        loop_en = 1'($urandom_range(0, 1));
        start = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) pause = ~pause;
      if ($urandom_range(0, 24) == 0) dir = ~dir;
      if ($urandom_range(0, 40) == 0) loop_en = ~loop_en;
      run_cycle("rand");
      start = 1'b0;
    end
    pause = 1'b0;

    // asynchronous reset mid-run at addr 7
    do_start(14'd0, 14'd20, 1'b0, 1'b1, "rst_start");
    run_until_step_at(14'd7, 40, "rst_to7");
    run_cycle("rst_pre");
    #2 sys_rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    run_n(2, "rst_hold");
    #2 sys_rst_n = 1'b1;
    run_n(12, "rst_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rom_addr_seq
